// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the imem UART loader.
package imem_load_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LEN, DATA, DONE} state_t;
  localparam int IMEM_AW_DEF = 16;
  localparam int LEN_BYTES   = 4;
endpackage

// File: rtl/imem_load_ctrl.sv
// Instruction-memory loader: passes CPU fetches through when idle, otherwise
// assembles a length-prefixed UART byte stream into little-endian imem words.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int IMEM_AW = IMEM_AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_imem,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               cpu_imem_rd,
  input  logic [IMEM_AW-1:0] cpu_imem_addr,
  output logic               imem_rd,
  output logic [IMEM_AW-3:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic [3:0]         imem_we,
  output logic               cpu_hold,
  output logic               cpu_reset_req,
  output logic               load_done,
  output logic               load_err
);
  localparam int WAW = IMEM_AW - 2;

  state_t         state, state_nxt;
  logic           load_q;
  logic [31:0]    len, len_full, byte_cnt, wbuf, wbuf_nxt;
  logic [1:0]     len_cnt;
  logic [3:0]     lane_mask, lane_bit, we_q;
  logic [WAW-1:0] wptr;
  logic           last_q;
  logic           start, len_bad, byte_last, rx_take, word_fire, wr_cycle;
  logic [1:0]     unused_addr_bits;

  assign unused_addr_bits = cpu_imem_addr[1:0];
  assign start     = load_imem && !load_q;
  assign len_bad   = {1'b0, len_full} > (33'd1 << IMEM_AW);
  assign byte_last = (byte_cnt + 32'd1) == len;
  // last_q blocks stray bytes once the final word has been handed off
  assign rx_take   = (state == DATA) && load_imem && rx_valid && !last_q;
  assign word_fire = rx_take && ((byte_cnt[1:0] == 2'd3) || byte_last);
  assign wr_cycle  = |we_q;
  assign lane_bit  = 4'b0001 << byte_cnt[1:0];

  always_comb begin
    len_full = len;
    len_full[8*len_cnt +: 8] = rx_data;
    wbuf_nxt = wbuf;
    wbuf_nxt[8*byte_cnt[1:0] +: 8] = rx_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cpu_hold      = 1'b1;
    imem_rd       = 1'b0;
    imem_addr     = wptr;
    imem_we       = 4'b0000;
    load_done     = 1'b0;
    cpu_reset_req = 1'b0;
    case (state)
      IDLE: begin
        cpu_hold  = 1'b0;
        imem_rd   = cpu_imem_rd;
        imem_addr = cpu_imem_addr[IMEM_AW-1:2];
        if (start) state_nxt = LEN;
      end
      LEN: begin
        if (!load_imem) state_nxt = IDLE;
        else if (rx_valid && len_cnt == 2'(LEN_BYTES - 1)) begin
          if (len_bad)             state_nxt = IDLE;
          else if (len_full == '0) state_nxt = DONE;
          else                     state_nxt = DATA;
        end
      end
      DATA: begin
        imem_we = we_q;
        if (!load_imem)           state_nxt = IDLE;
        else if (wr_cycle && last_q) state_nxt = DONE;
      end
      DONE: begin
        load_done     = 1'b1;
        cpu_reset_req = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      load_q     <= 1'b0;
      len        <= '0;
      len_cnt    <= '0;
      byte_cnt   <= '0;
      wbuf       <= '0;
      lane_mask  <= '0;
      we_q       <= '0;
      wptr       <= '0;
      last_q     <= 1'b0;
      imem_wdata <= '0;
      load_err   <= 1'b0;
    end else begin
      load_q <= load_imem;
      we_q   <= '0;
      case (state)
        IDLE: if (start) begin
          load_err  <= 1'b0;
          len       <= '0;
          len_cnt   <= '0;
          byte_cnt  <= '0;
          lane_mask <= '0;
          wptr      <= '0;
          last_q    <= 1'b0;
        end
        LEN: begin
          if (!load_imem) load_err <= 1'b1;
          else if (rx_valid) begin
            len     <= len_full;
            len_cnt <= len_cnt + 2'd1;
            if (len_cnt == 2'(LEN_BYTES - 1) && len_bad) load_err <= 1'b1;
          end
        end
        DATA: begin
          if (!load_imem) begin
            load_err  <= 1'b1;
            lane_mask <= '0;
          end else begin
            // pointer advances after its write cycle, never past the last word
            if (wr_cycle && !last_q) wptr <= wptr + 1'b1;
            if (rx_take) begin
              byte_cnt <= byte_cnt + 32'd1;
              if (word_fire) begin
                we_q       <= lane_mask | lane_bit;
                imem_wdata <= wbuf_nxt;
                lane_mask  <= '0;
                last_q     <= byte_last;
              end else begin
                wbuf      <= wbuf_nxt;
                lane_mask <= lane_mask | lane_bit;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter: IMEM_AW, default 16, imem byte-address width (64 KB).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 load_imem  input  1  level request to reload imem from the UART byte stream.
REQ-005 rx_valid  input  1  one-cycle strobe: rx_data holds a received UART byte.
REQ-006 rx_data  input  8  received byte.
REQ-007 cpu_imem_rd  input  1  CPU fetch read request.
REQ-008 cpu_imem_addr  input  IMEM_AW  CPU fetch byte address.
REQ-009 imem_rd  output  1  read enable to imem.
REQ-010 imem_addr  output  IMEM_AW-2  imem word address.
REQ-011 imem_wdata  output  32  write data; byte n on bits [8n+7:8n], little-endian.
REQ-012 imem_we  output  4  per-lane write enable, lane n = ram_symbol n.
REQ-013 cpu_hold  output  1  CPU must stall; imem owned by loader.
REQ-014 cpu_reset_req  output  1  one-cycle pulse: restart CPU at address 0.
REQ-015 load_done  output  1  one-cycle pulse: load finished successfully.
REQ-016 load_err  output  1  sticky error flag.

Function
REQ-017 FSM states SHALL be IDLE, LEN, DATA, DONE.
REQ-018 IDLE: imem_rd=cpu_imem_rd, imem_addr=cpu_imem_addr[IMEM_AW-1:2], imem_we=0, cpu_hold=0 (combinational pass-through, zero added latency).
REQ-019 Rising edge of load_imem (registered edge detect) in IDLE -> LEN; clear load_err, byte/word counters.
REQ-020 LEN, DATA, DONE: cpu_hold=1, imem_rd=0; imem_addr from loader word pointer.
REQ-021 LEN: accept 4 rx bytes as 32-bit length L, little-endian; after 4th byte -> DATA, or DONE if L==0.
REQ-022 L > 2^IMEM_AW -> set load_err, return to IDLE; no imem write.
REQ-023 DATA: each rx byte placed in lane byte_cnt[1:0]; lane enable bit set.
REQ-024 Lane 3 filled, or L-th byte received: next cycle imem_we = accumulated lane mask for exactly one cycle, imem_addr = word pointer; pointer then increments, mask clears.
REQ-025 Write is registered, FSM stays in DATA; rx_valid in the write cycle SHALL be accepted without loss.
REQ-026 Final partial word: only received lanes enabled (L=5 -> second write we=4'b0001).
REQ-027 After final write cycle -> DONE; DONE lasts one cycle: load_done=1, cpu_reset_req=1, then IDLE.
REQ-028 load_imem deasserted in LEN or DATA: abort next cycle to IDLE, set load_err, discard pending partial word, no pulses.
REQ-029 load_imem held high after DONE SHALL NOT restart; a new rising edge is required.
REQ-030 Rising edge of load_imem outside IDLE ignored.
REQ-031 Word pointer SHALL never wrap; max L guaranteed by REQ-022.

Reset
REQ-032 reset low at a clock edge: FSM=IDLE; counters, lane mask, word pointer, edge-detect register cleared.
REQ-033 Reset values: imem_we=0, cpu_hold=0, cpu_reset_req=0, load_done=0, load_err=0, imem_wdata=0; imem_rd/imem_addr follow CPU per REQ-018.
REQ-034 Reset mid-load: abort immediately, no further write, no load_done pulse.

Structure
REQ-035 Shared package: FSM state enum, IMEM_AW default, length-field byte count (4).
REQ-036 Single module; no sub-modules (byte assembler inline).

Verification
REQ-037 Idle fetch: cpu_imem_rd=1, addr=0x0104 -> same cycle imem_rd=1, imem_addr=0x041, we=0, cpu_hold=0.
REQ-038 Load L=8, bytes 13 00 00 00 | 93 00 10 00 -> we=4'hF addr 0 wdata 0x00000013, then addr 1 wdata 0x00100093; load_done and cpu_reset_req pulse once; cpu_hold drops.
REQ-039 Load L=5, bytes AA BB CC DD EE -> writes 0xDDCCBBAA we=4'hF addr 0, then we=4'b0001 addr 1 lane0=0xEE.
REQ-040 L=0 -> no writes, LEN->DONE, load_done pulse; L=0x00010001 -> load_err=1, no writes, IDLE.
REQ-041 Drop load_imem after 6 payload bytes of L=8 -> one write (addr 0), load_err=1, no load_done.
REQ-042 Back-to-back rx_valid every cycle through write cycles (L=12) -> 3 correct writes, no lost bytes.
